// File: rtl/imem_loader.sv
// Boot-time instruction-memory writer: parses a header/word/checksum byte stream,
// emits one 32-bit imem write per word and stalls the CPU until a good load completes.
module imem_loader #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [31:0]       mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_DATA,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_t;

  localparam logic [31:0]   DEPTH_U  = DEPTH;
  localparam logic [ADDR_W:0] WORD_ONE = {{ADDR_W{1'b0}}, 1'b1};

  state_t              r_state;
  state_t              w_next;
  logic [7:0]          r_acc;
  logic [1:0]          r_bcnt;
  logic [23:0]         r_shift;
  logic [ADDR_W:0]     r_n;
  logic [ADDR_W:0]     r_words;
  logic [ADDR_W-1:0]   r_addr;
  logic [31:0]         r_wdata;
  logic                r_we;

  logic                w_xfer;
  logic                w_over;
  logic                w_word_end;
  logic                w_last_word;

  assign w_xfer      = byte_valid && byte_ready;
  assign w_over      = {24'd0, byte_in} > DEPTH_U;
  assign w_word_end  = (r_state == S_DATA) && w_xfer && (r_bcnt == 2'd3);
  assign w_last_word = (r_words + WORD_ONE) == r_n;

  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    byte_ready = 1'b0;
    cpu_hold   = 1'b1;
    done       = 1'b0;
    error      = 1'b0;
    case (r_state)
      S_IDLE:   if (start) w_next = S_HEADER;
      S_HEADER: begin
        byte_ready = 1'b1;
        if (w_xfer) begin
          if (w_over)               w_next = S_ERROR;
          else if (byte_in == 8'd0) w_next = S_CHECK;
          else                      w_next = S_DATA;
        end
      end
      S_DATA: begin
        byte_ready = 1'b1;
        if (w_word_end && w_last_word) w_next = S_CHECK;
      end
      S_CHECK: begin
        byte_ready = 1'b1;
        if (w_xfer) w_next = (byte_in == r_acc) ? S_DONE : S_ERROR;
      end
      S_DONE: begin
        cpu_hold = 1'b0;
        done     = 1'b1;
        if (start) w_next = S_HEADER;
      end
      S_ERROR: begin
        error = 1'b1;
        if (start) w_next = S_HEADER;
      end
      default:  w_next = S_IDLE;
    endcase
  end

  // The write strobe is registered, so it appears the cycle after the 4th byte
  // of a word, together with the incremented word count.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_acc   <= '0;
      r_bcnt  <= '0;
      r_shift <= '0;
      r_n     <= '0;
      r_words <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_we    <= 1'b0;
    end else begin
      r_we <= 1'b0;
      case (r_state)
        S_HEADER: if (w_xfer) begin
          r_acc   <= byte_in;
          r_n     <= byte_in[ADDR_W:0];
          r_bcnt  <= '0;
          r_shift <= '0;
          r_words <= '0;
        end
        S_DATA: if (w_xfer) begin
          r_acc   <= r_acc ^ byte_in;
          r_bcnt  <= r_bcnt + 2'd1;
          r_shift <= {r_shift[15:0], byte_in};
          if (r_bcnt == 2'd3) begin
            r_we    <= 1'b1;
            r_wdata <= {r_shift, byte_in};
            r_addr  <= r_words[ADDR_W-1:0];
            r_words <= r_words + WORD_ONE;
          end
        end
        S_DONE, S_ERROR: if (start) r_words <= '0;
        default: ;
      endcase
    end
  end

  assign mem_we       = r_we;
  assign mem_addr     = {{(30-ADDR_W){1'b0}}, r_addr, 2'b00};
  assign mem_wdata    = r_wdata;
  assign words_loaded = r_words;

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time writer for the instruction memory: the write side of the imem that the IF stage reads by word-aligned byte address.
- Accepts a byte stream (header, big-endian instruction words, checksum) over a valid/ready interface.
- Issues one 32-bit write per assembled word.
- Holds the CPU (PC and IF/ID write disabled) until a load completes with a correct checksum.

Parameters:
- DEPTH, 64: imem size in words; maximum accepted header count.
- ADDR_W, 6: clog2(DEPTH); width of the word index.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  pulse; begins a load from IDLE, DONE or ERROR.
- byte_in  in  8  stream byte.
- byte_valid  in  1  byte_in is valid this cycle.
- byte_ready  out  1  loader accepts a byte this cycle.
- mem_we  out  1  one-cycle imem write strobe.
- mem_addr  out  32  imem byte address: word index × 4, bits[1:0] always 0.
- mem_wdata  out  32  word to write.
- cpu_hold  out  1  1 = stall CPU; drives PC_Write=0 and IF_ID_Write=0 upstream.
- done  out  1  load completed with a good checksum.
- error  out  1  load rejected.
- words_loaded  out  ADDR_W+1  count of words written in the current load.

Behaviour:
- Reset values: state IDLE, byte_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=1, done=0, error=0, words_loaded=0. Checksum accumulator, byte counter and shift register are cleared.
- Reset mid-load: same values, taking effect on the next edge. Words already written to imem are not erased.
- Transfer occurs only on a cycle with byte_valid && byte_ready. byte_valid while byte_ready=0 is ignored; the sender holds the byte.
- byte_ready=1 only in HEADER, DATA and CHECK.
- cpu_hold=0 only in DONE.
- done=1 only in DONE; error=1 only in ERROR.
- IDLE:
  - start -> HEADER.
- HEADER: accept one byte N; checksum accumulator = N.
  - N > DEPTH -> ERROR.
  - N == 0 -> CHECK.
  - Otherwise -> DATA, with words_loaded=0.
- DATA:
  - Each accepted byte is XORed into the accumulator and shifted into the word.
  - The first byte of a word lands in bits[31:24] (big-endian, MIPS order).
  - On the 4th byte, in the following cycle: mem_we=1 for exactly one cycle, mem_addr = words_loaded×4, mem_wdata = assembled word.
  - words_loaded increments on that same edge (latency from 4th byte to strobe is 1 cycle).
  - When the Nth word's 4th byte is accepted -> CHECK. The final write strobe may overlap the first CHECK cycle.
- CHECK: accept one byte.
  - Byte equals accumulator -> DONE.
  - Otherwise -> ERROR.
- DONE: hold until start or reset.
  - start -> HEADER; cpu_hold=1 and done=0 on the same edge; words_loaded cleared.
- ERROR: same as DONE.
  - start -> HEADER; error cleared on the same edge.
- start while in HEADER, DATA or CHECK is ignored.
- mem_addr and mem_wdata hold their last values when mem_we=0.
- Wrap: the word index never exceeds DEPTH-1 because of the header check. Last legal address is (DEPTH-1)×4 = 0xFC.

Test Plan:
- Nominal load:
  - Stimulus: reset, start, header 0x02, bytes 24 08 00 05 00 00 00 20, checksum 0x0B.
  - Response: mem_we at addr 0x0 with data 0x24080005, then addr 0x4 with data 0x00000020; done=1, cpu_hold=0, words_loaded=2.
- Bad checksum:
  - Stimulus: same stream with checksum 0x0C.
  - Response: both writes occur; error=1, done=0, cpu_hold=1, byte_ready=0.
- Oversize header:
  - Stimulus: header 0x41 with DEPTH=64.
  - Response: error=1 on the edge after the header; no mem_we; further bytes not accepted.
- Empty load:
  - Stimulus: header 0x00, checksum 0x00.
  - Response: done=1, no mem_we, words_loaded=0.
- Throttling and reset mid-load:
  - Stimulus: byte_valid toggled every other cycle on the nominal stream.
  - Response: identical writes and result.
  - Stimulus: separately, reset after 2 data bytes.
  - Response: all outputs at reset values, no mem_we; a following start plus the full stream ends in done=1.
- Full depth:
  - Stimulus: header 0x40 and 64 words with data = index.
  - Response: last write at addr 0xFC with data 0x0000003F; words_loaded=64, done=1.
